// File: rtl/seq_detect_ctrl.sv
// Run-controlled, reconfigurable serial sequence detector.
// Holds pattern/length/overlap/threshold config, frames the x stream during RUN,
// pulses y on each match and counts matches until the threshold or a stop.
module seq_detect_ctrl #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [4:0]       LenMax     = 5'(PAT_W);
    localparam logic [PAT_W-1:0] PatDefault = PAT_W'(8'b0000_1101);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [3:0]         len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic               cfg_err_q, cfg_err_d;
    logic [PAT_W-1:0]   sh_q, sh_d;
    logic [3:0]         fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               y_q, y_d;

    logic [PAT_W-1:0]   sh_new;
    logic [PAT_W-1:0]   len_mask;
    logic [4:0]         fill_inc;
    logic [4:0]         len_ext;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cfg_legal;
    logic               match;

    assign sh_new    = {sh_q[PAT_W-2:0], x};
    assign fill_inc  = {1'b0, fill_q} + 5'd1;
    assign len_ext   = {1'b0, len_q};
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign cfg_legal = (cfg_len != 4'd0) && ({1'b0, cfg_len} <= LenMax);

    // Mask selecting the low len_q bits of pattern and shift register.
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            len_mask[i] = (5'(i) < len_ext);
        end
    end

    assign match = (fill_inc >= len_ext) && (((sh_new ^ pat_q) & len_mask) == '0);

    // Next-state: config latch, run sequencing, shift/fill/count updates.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        thr_d     = thr_q;
        cfg_err_d = cfg_err_q;
        sh_d      = sh_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        y_d       = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // Config is latched first so start sees the updated error flag.
                if (cfg_we) begin
                    if (cfg_legal) begin
                        pat_d     = cfg_pattern;
                        len_d     = cfg_len;
                        ovl_d     = cfg_overlap;
                        thr_d     = cfg_thresh;
                        cfg_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (start && !cfg_err_d) begin
                    state_d = StRun;
                    sh_d    = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    // The bit sampled alongside stop is dropped.
                    state_d = StIdle;
                end else if (x_valid) begin
                    sh_d   = sh_new;
                    fill_d = (fill_inc >= len_ext) ? len_q : fill_inc[3:0];
                    if (match) begin
                        y_d   = 1'b1;
                        cnt_d = cnt_inc;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if ((thr_q != '0) && (cnt_inc == thr_q)) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            pat_q     <= PatDefault;
            len_q     <= 4'd4;
            ovl_q     <= 1'b1;
            thr_q     <= '0;
            cfg_err_q <= 1'b0;
            sh_q      <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            y_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            thr_q     <= thr_d;
            cfg_err_q <= cfg_err_d;
            sh_q      <= sh_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
        end
    end

    assign y           = y_q;
    assign match_count = cnt_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: table-driven vectors with a scoreboard queue.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = 8'h0D;
    logic [3:0]       cfg_len = 4'd4;
    logic             cfg_overlap = 1'b1;
    logic [CNT_W-1:0] cfg_thresh = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             x = 1'b0;
    logic             x_valid = 1'b0;
    logic             y;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;
    logic             cfg_err;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_thresh  (cfg_thresh),
        .start       (start),
        .stop        (stop),
        .x           (x),
        .x_valid     (x_valid),
        .y           (y),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic       st;
        logic       sp;
        logic       xv;
        logic       xb;
        logic       ey;
        logic [7:0] ecnt;
        logic       ebusy;
        logic       edone;
        logic       eerr;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_run = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic rst, we, st, sp, xv, xb,
                                input logic ey, input logic [7:0] ecnt,
                                input logic ebusy, edone, eerr);
        vec_t v;
        v.rst = rst; v.we = we; v.st = st; v.sp = sp; v.xv = xv; v.xb = xb;
        v.ey = ey; v.ecnt = ecnt; v.ebusy = ebusy; v.edone = edone; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        reset = v.rst; cfg_we = v.we; start = v.st; stop = v.sp; x_valid = v.xv; x = v.xb;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".y"},    32'(y),           32'(e.ey));
            chk({tag, ".cnt"},  32'(match_count), 32'(e.ecnt));
            chk({tag, ".busy"}, 32'(busy),        32'(e.ebusy));
            chk({tag, ".done"}, 32'(done),        32'(e.edone));
            chk({tag, ".err"},  32'(cfg_err),     32'(e.eerr));
        end
    endtask

    task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len,
                           input logic ovl, input logic [7:0] thr);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_thresh = thr;
    endtask

    logic       strm [0:9] = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 1};
    logic       hit  [0:9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    logic       y11o [0:3] = '{0, 1, 1, 1};
    logic       y11n [0:3] = '{0, 1, 0, 1};
    logic [7:0] c11o [0:3] = '{0, 1, 2, 3};
    logic [7:0] c11n [0:3] = '{0, 1, 1, 2};

    initial begin
        logic [7:0] cnt;
        logic       fin;

        // Default-config stream table: start, then 1101011011.
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 2, 1, 0, 0));

        // Reset held low with random inputs.
        for (int i = 0; i < 3; i++) begin
            set_cfg(8'($urandom), 4'($urandom), 1'($urandom), 8'($urandom));
            apply(mk(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 0, 0, 0, 0, 0), "reset");
        end
        set_cfg(8'h00, 4'd0, 1'b0, 8'h00);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_after_reset");

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Pattern 11, overlap on then off.
        for (int ov = 1; ov >= 0; ov--) begin
            apply(mk(1, 0, 0, 1, 1, 1, 0, (ov == 1) ? 8'd2 : 8'd3, 0, 0, 0), "stop_prev");
            set_cfg(8'b0000_0011, 4'd2, 1'(ov), 8'd0);
            apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0), "cfg11_start");
            for (int i = 0; i < 4; i++) begin
                apply(mk(1, 0, 0, 0, 1, 1, (ov == 1) ? y11o[i] : y11n[i],
                         (ov == 1) ? c11o[i] : c11n[i], 1, 0, 0),
                      $sformatf("p11_ov%0d_b%0d", ov, i + 1));
            end
        end

        // Threshold 2, alternate-cycle valid; cfg_we during RUN must be ignored.
        apply(mk(1, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0), "stop_p11");
        set_cfg(8'b0000_1101, 4'd4, 1'b1, 8'd2);
        apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0), "thr_start");
        set_cfg(8'h00, 4'd0, 1'b0, 8'd0);
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "we_in_run");
        cnt = 0;
        fin = 0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + 8'(hit[i]);
            fin = (i == 8);
            apply(mk(1, 0, 0, 0, 1, strm[i], hit[i], cnt, !fin, fin, 0),
                  $sformatf("thr_b%0d", i + 1));
            apply(mk(1, 0, 0, 0, 0, !strm[i], 0, cnt, !fin, fin, 0),
                  $sformatf("thr_gap%0d", i + 1));
        end
        apply(mk(1, 0, 0, 0, 1, strm[9], 0, 2, 0, 1, 0), "thr_b10_ignored");
        apply(mk(1, 0, 0, 1, 0, 0, 0, 2, 0, 1, 0), "stop_in_done");
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "restart");

        // Stop on the edge that samples the completing bit of 1101.
        apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "stop_restart");
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "stop_t_start");
        apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0), "stop_t_b1");
        apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0), "stop_t_b2");
        apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), "stop_t_b3");
        apply(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0), "stop_t_b4");
        apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "stop_t_idle");

        // Illegal configs block start; a legal write clears the flag.
        set_cfg(8'hFF, 4'd0, 1'b0, 8'd1);
        apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1), "len0_we_start");
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "start_blocked");
        set_cfg(8'b0000_0011, 4'd2, 1'b1, 8'd1);
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "legal_clears");
        set_cfg(8'hFF, 4'd9, 1'b0, 8'd1);
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "len9_rejected");
        set_cfg(8'b0000_0011, 4'd2, 1'b1, 8'd1);
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "legal_again");

        // Reset mid-run restores the default config (1101, no threshold).
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "rst_t_start");
        apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0), "rst_t_b1");
        apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "rst_mid_run");
        set_cfg(8'h00, 4'd0, 1'b0, 8'd0);
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "dflt_start");
        apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0), "dflt_b1");
        apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0), "dflt_b2");
        apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), "dflt_b3");
        apply(mk(1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0), "dflt_b4");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "dflt_hold");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
